// File: rtl/tdm_demux_4.sv
// Receive end of a 4-slot TDM link: locks to the frame marker, collects beats and presents whole frames.
// Optional build macro TDM_DEMUX_ERR_CNT_EN adds a saturating sync-error counter on err_count.
module tdm_demux_4 #(
    parameter int unsigned W = 2
) (
    input  logic         CLOCK_50,
    input  logic         RESET_N,
    input  logic         in_valid,
    input  logic         in_sync,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic         frame_valid,
    output logic         locked,
`ifdef TDM_DEMUX_ERR_CNT_EN
    output logic [7:0]   err_count,
`endif
    output logic         sync_error
);

    localparam int unsigned SLOT_W = 2;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state;
    logic [SLOT_W-1:0]   slot;
    logic [W-1:0]        shadow0;
    logic [W-1:0]        shadow1;
    logic [W-1:0]        shadow2;
    logic                err_event_c;

    // A framing violation: marker missing at slot 0, or marker arriving mid-frame.
    assign err_event_c = in_valid && (state == LOCKED) &&
                         (((slot == SLOT_W'(0)) && !in_sync) ||
                          ((slot != SLOT_W'(0)) && in_sync));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= HUNT;
            slot        <= SLOT_W'(0);
            shadow0     <= W'(0);
            shadow1     <= W'(0);
            shadow2     <= W'(0);
            y0          <= W'(0);
            y1          <= W'(0);
            y2          <= W'(0);
            y3          <= W'(0);
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_error  <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (in_sync) begin
                            shadow0 <= in_data;
                            slot    <= SLOT_W'(1);
                            state   <= LOCKED;
                            locked  <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (slot == SLOT_W'(0)) begin
                            if (in_sync) begin
                                shadow0 <= in_data;
                                slot    <= SLOT_W'(1);
                            end else begin
                                sync_error <= 1'b1;
                                state      <= HUNT;
                                locked     <= 1'b0;
                                slot       <= SLOT_W'(0);
                            end
                        end else if (in_sync) begin
                            // Resync: the partial frame is dropped, this beat starts a new one.
                            sync_error <= 1'b1;
                            shadow0    <= in_data;
                            slot       <= SLOT_W'(1);
                        end else begin
                            slot <= slot + SLOT_W'(1);
                            case (slot)
                                SLOT_W'(1): shadow1 <= in_data;
                                SLOT_W'(2): shadow2 <= in_data;
                                default: begin
                                    y0          <= shadow0;
                                    y1          <= shadow1;
                                    y2          <= shadow2;
                                    y3          <= in_data;
                                    frame_valid <= 1'b1;
                                end
                            endcase
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        slot   <= SLOT_W'(0);
                    end
                endcase
            end
        end
    end

`ifdef TDM_DEMUX_ERR_CNT_EN
    // Saturating count of framing violations; cleared only by reset.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            err_count <= 8'd0;
        end else if (err_event_c && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed self-checking bench for tdm_demux_4 with hand-computed expectations.
// Covers the TDM_DEMUX_ERR_CNT_EN build when that macro is defined.
module tb_tdm_demux_4;

    localparam int unsigned W = 2;

    logic         CLOCK_50;
    logic         RESET_N;
    logic         in_valid;
    logic         in_sync;
    logic [W-1:0] in_data;
    logic [W-1:0] y0, y1, y2, y3;
    logic         frame_valid;
    logic         locked;
    logic         sync_error;
`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0]   err_count;
`endif

    int total;
    int bad;

    tdm_demux_4 #(.W(W)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .in_valid    (in_valid),
        .in_sync     (in_sync),
        .in_data     (in_data),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .frame_valid (frame_valid),
        .locked      (locked),
`ifdef TDM_DEMUX_ERR_CNT_EN
        .err_count   (err_count),
`endif
        .sync_error  (sync_error)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and return 1 time unit after the edge.
    task automatic cyc(input logic v, input logic s, input logic [W-1:0] d);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge CLOCK_50);
        #1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic check_y(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, ".y0"}, int'(y0), e0);
        check({tag, ".y1"}, int'(y1), e1);
        check({tag, ".y2"}, int'(y2), e2);
        check({tag, ".y3"}, int'(y3), e3);
    endtask

    // Four consecutive beats starting at slot 0; frame_valid only after the last one.
    task automatic frame(input string tag, input int d0, input int d1, input int d2, input int d3);
        cyc(1'b1, 1'b1, W'(d0));
        check({tag, ".fv0"}, int'(frame_valid), 0);
        cyc(1'b1, 1'b0, W'(d1));
        check({tag, ".fv1"}, int'(frame_valid), 0);
        cyc(1'b1, 1'b0, W'(d2));
        check({tag, ".fv2"}, int'(frame_valid), 0);
        cyc(1'b1, 1'b0, W'(d3));
        check({tag, ".fv3"}, int'(frame_valid), 1);
        check({tag, ".se"}, int'(sync_error), 0);
        check({tag, ".lk"}, int'(locked), 1);
        check_y(tag, d0, d1, d2, d3);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = '0;
        RESET_N  = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst.fv", int'(frame_valid), 0);
        check("rst.lk", int'(locked), 0);
        check("rst.se", int'(sync_error), 0);
        check_y("rst", 0, 0, 0, 0);
        RESET_N = 1'b1;
        cyc(1'b0, 1'b0, W'(0));

        // Test 1: first frame from HUNT
        cyc(1'b1, 1'b1, W'(1));
        check("t1.lk_after_sync", int'(locked), 1);
        check("t1.fv_b0", int'(frame_valid), 0);
        cyc(1'b1, 1'b0, W'(2));
        cyc(1'b1, 1'b0, W'(3));
        check("t1.fv_b2", int'(frame_valid), 0);
        check_y("t1.held", 0, 0, 0, 0);
        cyc(1'b1, 1'b0, W'(0));
        check("t1.fv", int'(frame_valid), 1);
        check("t1.lk", int'(locked), 1);
        check_y("t1", 1, 2, 3, 0);
        cyc(1'b0, 1'b0, W'(0));
        check("t1.fv_pulse", int'(frame_valid), 0);
        check_y("t1.hold", 1, 2, 3, 0);

        // Test 2: back-to-back frames
        frame("t2a", 0, 1, 2, 3);
        frame("t2b", 3, 2, 1, 0);
        frame("t2c", 2, 2, 2, 2);

        // Test 3: resync mid-frame
        cyc(1'b1, 1'b1, W'(1));
        cyc(1'b1, 1'b0, W'(2));
        cyc(1'b1, 1'b1, W'(3));
        check("t3.se", int'(sync_error), 1);
        check("t3.fv", int'(frame_valid), 0);
        check("t3.lk", int'(locked), 1);
        check_y("t3.held", 2, 2, 2, 2);
        cyc(1'b1, 1'b0, W'(0));
        check("t3.se_pulse", int'(sync_error), 0);
        cyc(1'b1, 1'b0, W'(1));
        check("t3.fv_early", int'(frame_valid), 0);
        cyc(1'b1, 1'b0, W'(2));
        check("t3.fv", int'(frame_valid), 1);
        check_y("t3", 3, 0, 1, 2);

        // Test 4: lost lock at slot 0, silent hunt, relock
        cyc(1'b1, 1'b0, W'(1));
        check("t4.se", int'(sync_error), 1);
        check("t4.lk", int'(locked), 0);
        check("t4.fv", int'(frame_valid), 0);
        cyc(1'b1, 1'b0, W'(2));
        check("t4.hunt_se", int'(sync_error), 0);
        check("t4.hunt_lk", int'(locked), 0);
        cyc(1'b1, 1'b0, W'(3));
        check("t4.hunt_se2", int'(sync_error), 0);
        check_y("t4.held", 3, 0, 1, 2);
        cyc(1'b1, 1'b1, W'(1));
        check("t4.relock", int'(locked), 1);
        check("t4.relock_se", int'(sync_error), 0);
        cyc(1'b1, 1'b0, W'(2));
        cyc(1'b1, 1'b0, W'(3));
        cyc(1'b1, 1'b0, W'(0));
        check("t4.fv", int'(frame_valid), 1);
        check_y("t4", 1, 2, 3, 0);

        // Test 5: gapped beats
        frame("t5pre", 3, 3, 3, 3);
        cyc(1'b1, 1'b1, W'(1));
        for (int i = 0; i < 3; i++) begin
            repeat (2) begin
                cyc(1'b0, 1'b1, W'(3));
                check("t5.gap_fv", int'(frame_valid), 0);
                check("t5.gap_se", int'(sync_error), 0);
            end
            cyc(1'b1, 1'b0, W'((i + 2) % 4));
            check("t5.beat_fv", int'(frame_valid), (i == 2) ? 1 : 0);
        end
        check_y("t5", 1, 2, 3, 0);
        check("t5.lk", int'(locked), 1);

        // Test 5b: reset mid-frame
        cyc(1'b1, 1'b1, W'(2));
        cyc(1'b1, 1'b0, W'(1));
        RESET_N = 1'b0;
        #2;
        check("t5r.lk", int'(locked), 0);
        check("t5r.fv", int'(frame_valid), 0);
        check("t5r.se", int'(sync_error), 0);
        check_y("t5r", 0, 0, 0, 0);
        #2;
        RESET_N = 1'b1;
        cyc(1'b1, 1'b0, W'(3));
        check("t5r.hunt_se", int'(sync_error), 0);
        check("t5r.hunt_lk", int'(locked), 0);
        cyc(1'b1, 1'b0, W'(0));
        check("t5r.hunt_fv", int'(frame_valid), 0);
        check_y("t5r.after", 0, 0, 0, 0);

`ifdef TDM_DEMUX_ERR_CNT_EN
        // Test 6: saturating error counter
        RESET_N = 1'b0;
        #2;
        check("t6.rst", int'(err_count), 0);
        RESET_N = 1'b1;
        cyc(1'b0, 1'b0, W'(0));
        for (int i = 1; i <= 300; i++) begin
            cyc(1'b1, 1'b1, W'(0));
            cyc(1'b1, 1'b0, W'(1));
            cyc(1'b1, 1'b0, W'(2));
            cyc(1'b1, 1'b0, W'(3));
            cyc(1'b1, 1'b0, W'(0));
            if (i == 1)   check("t6.cnt1", int'(err_count), 1);
            if (i == 254) check("t6.cnt254", int'(err_count), 254);
            if (i == 255) check("t6.cnt255", int'(err_count), 255);
        end
        check("t6.sat", int'(err_count), 255);
        check("t6.lk", int'(locked), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // frame_valid and sync_error must never coincide.
    always @(negedge CLOCK_50) begin
        if (RESET_N && frame_valid && sync_error) begin
            check("excl", 1, 0);
        end
    end

endmodule
